ifetch: RTL

Instruction fetch stage sitting directly upstream of the main decoder. It owns the PC, issues word-aligned read requests to instruction memory over a request/grant/response interface, and buffers returned words in a small in-order FIFO. It presents one instruction at a time to decode with a valid/ready handshake. A redirect from the branch/jump logic flushes the FIFO and discards in-flight responses.

---
 rtl/ifetch.sv | 105 ++++++++++
 1 files changed

// File: rtl/ifetch.sv
// Instruction fetch stage: owns the PC, requests words from instruction memory
// under a credit limit, and buffers responses in an in-order FIFO for decode.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   fifo_word [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] stale;

  logic          grant;
  logic          push;
  logic          pop;
  logic [CW-1:0] out_next;
  logic [CW:0]   credits_used;
  logic [31:0]   target_pc;
  logic          unused_redirect_bits;

  // Handshakes: imem request transfers when imem_req && imem_gnt; decode
  // consumes the head when instr_valid && instr_ready. Both sides hold
  // their offer stable until the transfer.
  assign credits_used = {1'b0, count} + {1'b0, outstanding};
  assign imem_req     = !reset && (credits_used < (CW+1)'(DEPTH));
  assign imem_addr    = fetch_pc;
  assign grant        = imem_req && imem_gnt;
  assign out_next     = outstanding + CW'(grant) - CW'(imem_rvalid);
  assign push         = imem_rvalid && (stale == '0) && !redirect && !reset;
  assign instr_valid  = (count != '0);
  assign pop          = instr_valid && instr_ready;
  assign instr        = instr_valid ? fifo_word[rd_ptr] : 32'h0;
  assign instr_pc     = instr_valid ? fifo_pc[rd_ptr] : 32'h0;

  assign target_pc            = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_bits = ^redirect_pc[1:0];

  // Storage needs no reset: count gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_word[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]   <= resp_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      stale       <= '0;
    end else if (redirect) begin
      // Everything still in flight after this cycle's accounting is stale.
      fetch_pc    <= target_pc;
      resp_pc     <= target_pc;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= out_next;
      stale       <= out_next;
    end else begin
      outstanding <= out_next;
      if (grant) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (imem_rvalid && (stale != '0)) begin
        stale <= stale - CW'(1);
      end
      if (push) begin
        wr_ptr  <= wr_ptr + AW'(1);
        resp_pc <= resp_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule
